puf_cr_sequencer: RTL and testbench

//  Challenge-response initiator that drives the 64-RO race PUF core. Per response bit it issues a

---
 rtl/puf_cr_sequencer_pkg.sv | 20 ++
 rtl/puf_cr_sequencer_sync_ff.sv | 20 ++
 rtl/puf_cr_sequencer.sv | 179 +++++++++++++++++
 tb/tb_puf_cr_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_cr_sequencer_pkg.sv
// Shared types for the PUF challenge-response sequencer: FSM states, race decision
// encoding and a width helper.
package puf_seq_pkg;

  localparam int CHAL_W_DEF = 10;

  typedef enum logic [2:0] {IDLE, ARM, RUN, SAMPLE, DONE} state_t;

  // Outcome of one race, latched when RUN exits so SAMPLE sees a stable verdict
  typedef enum logic [1:0] {DEC_ZERO, DEC_ONE, DEC_TMO} dec_t;

  // Bits needed to count 0..value-1; never narrower than one bit
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/puf_cr_sequencer_sync_ff.sv
// Multi-flop synchroniser for one asynchronous PUF status line; clears to 0 on reset.
module puf_sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) chain <= '0;
    else       chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/puf_cr_sequencer.sv
// Challenge-response initiator for the 64-RO race PUF: arms, races and samples one bit per race
// and returns an NBITS word over valid/ready. Define VON_NEUMANN_DEBIAS_EN for paired-race debiasing.
module puf_cr_sequencer
  import puf_seq_pkg::*;
#(
  parameter int NBITS       = 64,
  parameter int CHAL_W      = CHAL_W_DEF,
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 4194304,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [CHAL_W-1:0] seed,
  output logic              busy,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [NBITS-1:0]  response,
  output logic              timeout_err,
  output logic [63:0]       ro_enable,
  output logic [CHAL_W-1:0] challenge,
  output logic              cnt_reset,
  input  logic              cnt1_finish,
  input  logic              cnt2_finish,
  input  logic              cnt1_led
);

  localparam int IDX_W = clog2(NBITS);
  localparam int TMO_W = clog2(TIMEOUT_CYC);
  localparam int SET_W = clog2(SETTLE_CYC);

  logic [2:0] status_async;
  logic [2:0] status_sync;
  logic       fin1, fin2, led;

  assign status_async = {cnt1_led, cnt2_finish, cnt1_finish};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      puf_sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (status_async[gi]),
        .q     (status_sync[gi])
      );
    end
  endgenerate

  assign fin1 = status_sync[0];
  assign fin2 = status_sync[1];
  assign led  = status_sync[2];

  state_t            state;
  dec_t              dec;
  logic [CHAL_W-1:0] seed_reg, chal_off, next_off;
  logic [IDX_W-1:0]  idx;
  logic [TMO_W-1:0]  tmo;
  logic [SET_W-1:0]  settle;
  logic              race_bit, do_store, store_bit, advance;
`ifdef VON_NEUMANN_DEBIAS_EN
  logic              second, first_bit;
`endif

  assign next_off = chal_off + CHAL_W'(1);

  // Decide what the just-finished race contributes to the word
  always_comb begin
    race_bit = (dec == DEC_ONE);
`ifdef VON_NEUMANN_DEBIAS_EN
    advance   = (dec == DEC_TMO) || second;
    do_store  = second && (dec != DEC_TMO) && (first_bit != race_bit);
    store_bit = first_bit;
`else
    advance   = 1'b1;
    do_store  = 1'b1;
    store_bit = race_bit;
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      dec         <= DEC_ZERO;
      busy        <= 1'b0;
      resp_valid  <= 1'b0;
      response    <= '0;
      timeout_err <= 1'b0;
      ro_enable   <= '0;
      challenge   <= '0;
      cnt_reset   <= 1'b1;
      seed_reg    <= '0;
      chal_off    <= '0;
      idx         <= '0;
      tmo         <= '0;
      settle      <= '0;
`ifdef VON_NEUMANN_DEBIAS_EN
      second      <= 1'b0;
      first_bit   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          cnt_reset <= 1'b1;
          ro_enable <= '0;
          if (start) begin
            seed_reg    <= seed;
            challenge   <= seed;
            chal_off    <= '0;
            idx         <= '0;
            settle      <= '0;
            response    <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b1;
`ifdef VON_NEUMANN_DEBIAS_EN
            second      <= 1'b0;
`endif
            state       <= ARM;
          end
        end
        ARM: begin
          if (settle == SET_W'(SETTLE_CYC - 1)) begin
            cnt_reset <= 1'b0;
            ro_enable <= '1;
            tmo       <= '0;
            state     <= RUN;
          end else begin
            settle <= settle + SET_W'(1);
          end
        end
        RUN: begin
          // A finish seen on the same cycle as the timeout limit still counts as a finish
          if (fin1 || fin2) begin
            ro_enable <= '0;
            dec       <= (fin1 && fin2) ? (led ? DEC_ONE : DEC_ZERO) : (fin1 ? DEC_ONE : DEC_ZERO);
            state     <= SAMPLE;
          end else if (tmo == TMO_W'(TIMEOUT_CYC - 1)) begin
            ro_enable <= '0;
            dec       <= DEC_TMO;
            state     <= SAMPLE;
          end else begin
            tmo <= tmo + TMO_W'(1);
          end
        end
        SAMPLE: begin
          if (dec == DEC_TMO) timeout_err <= 1'b1;
          if (do_store) response[idx] <= store_bit;
`ifdef VON_NEUMANN_DEBIAS_EN
          second    <= ~advance;
          first_bit <= race_bit;
`endif
          cnt_reset <= 1'b1;
          if (do_store && (idx == IDX_W'(NBITS - 1))) begin
            resp_valid <= 1'b1;
            state      <= DONE;
          end else begin
            if (do_store) idx <= idx + IDX_W'(1);
            if (advance) begin
              chal_off  <= next_off;
              challenge <= seed_reg + next_off;
            end
            settle <= '0;
            state  <= ARM;
          end
        end
        DONE: begin
          cnt_reset <= 1'b1;
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_cr_sequencer.sv
// Bench for puf_cr_sequencer: behavioural PUF core, spec-level response/challenge model and
// a per-cycle compare process, plus directed requests with literal expected words.
module tb_puf_cr_sequencer;

  localparam int NB = 64;
  localparam int CW = 10;
  localparam int SC = 16;
  localparam int TC = 64;
  localparam int SS = 2;
  localparam int DW = 3;
  localparam int M_FIN1 = 0, M_SAME = 1, M_NONE = 2, M_PAT = 3;
`ifdef VON_NEUMANN_DEBIAS_EN
  localparam bit VN_EN = 1'b1;
`else
  localparam bit VN_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset, start, resp_ready;
  logic [CW-1:0] seed;
  logic          busy, resp_valid, timeout_err, cnt_reset;
  logic [NB-1:0] response;
  logic [63:0]   ro_enable;
  logic [CW-1:0] challenge;
  logic          cnt1_finish, cnt2_finish, cnt1_led;

  int            compared   = 0;
  int            mismatched = 0;
  int            mode       = M_FIN1;
  logic [CW-1:0] seed_v     = '0;
  logic [CW-1:0] chal_log [0:255];

  always #5 clock = ~clock;

  puf_cr_sequencer #(
    .NBITS(NB), .CHAL_W(CW), .SETTLE_CYC(SC), .TIMEOUT_CYC(TC), .SYNC_STAGES(SS)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .seed(seed), .busy(busy),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .response(response),
    .timeout_err(timeout_err), .ro_enable(ro_enable), .challenge(challenge),
    .cnt_reset(cnt_reset), .cnt1_finish(cnt1_finish), .cnt2_finish(cnt2_finish),
    .cnt1_led(cnt1_led)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Winner of race r within a request (1 = counter 1 first)
  function automatic bit race_win(input int m, input int r);
    case (m)
      M_FIN1:  return 1'b1;
      M_SAME:  return (r % 2) == 0;
      M_PAT:   return (r % 3) != 2;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [NB-1:0] model_resp(input int m);
    logic [NB-1:0] w;
    int k, r;
    w = '0;
    if (!VN_EN) begin
      for (int i = 0; i < NB; i++) w[i] = race_win(m, i);
    end else begin
      k = 0;
      r = 0;
      while (k < NB && r < 100000) begin
        if (race_win(m, r) != race_win(m, r + 1)) begin
          w[k] = race_win(m, r);
          k++;
        end
        r += 2;
      end
    end
    return w;
  endfunction

  function automatic logic [CW-1:0] model_chal(input logic [CW-1:0] s, input int r);
    int step;
    step = VN_EN ? (r / 2) : r;
    return s + CW'(step);
  endfunction

  // Behavioural PUF core: counters finish a fixed time after enables rise, cleared by cnt_reset
  initial begin
    int  puf_race, race_cyc, cur;
    bit  in_race, w;
    cnt1_finish = 1'b0;
    cnt2_finish = 1'b0;
    cnt1_led    = 1'b0;
    puf_race = 0; race_cyc = 0; cur = 0; in_race = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (!busy) puf_race = 0;
      if (reset || cnt_reset) begin
        cnt1_finish = 1'b0;
        cnt2_finish = 1'b0;
        in_race     = 1'b0;
      end else if (ro_enable == '1 && !in_race) begin
        in_race  = 1'b1;
        race_cyc = 0;
        cur      = puf_race;
        puf_race++;
        cnt1_led = (mode == M_SAME) && ((cur % 2) == 0);
      end
      if (in_race) begin
        race_cyc++;
        w = race_win(mode, cur);
        if (mode == M_SAME) begin
          if (race_cyc == DW) begin
            cnt1_finish = 1'b1;
            cnt2_finish = 1'b1;
          end
        end else if (mode != M_NONE) begin
          if (race_cyc == DW) begin
            if (w) cnt1_finish = 1'b1;
            else   cnt2_finish = 1'b1;
          end else if (race_cyc == DW + 2) begin
            if (w) cnt2_finish = 1'b1;
            else   cnt1_finish = 1'b1;
          end
        end
      end
    end
  end

  // Per-cycle compare against the model
  initial begin
    int c_race, ro_len, cr_run, last_run;
    bit prev_ro;
    c_race = 0; ro_len = 0; cr_run = 0; last_run = 0; prev_ro = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        c_race = 0; ro_len = 0; cr_run = 0; prev_ro = 1'b0;
      end else begin
        if (!busy) c_race = 0;
        if (cnt_reset) cr_run++;
        else begin
          if (cr_run != 0) last_run = cr_run;
          cr_run = 0;
        end
        check("ro_uniform", 64'((ro_enable == '0) || (ro_enable == '1)), 64'd1);
        check("en_with_cnt_reset", 64'((ro_enable == '1) && cnt_reset), 64'd0);
        if (ro_enable == '1 && !prev_ro) begin
          check("race_challenge", 64'(challenge), 64'(model_chal(seed_v, c_race)));
          if (c_race < 256) chal_log[c_race] = challenge;
          if (c_race > 0) check("settle_len", 64'(last_run), 64'(SC));
          else            check("settle_min", 64'(last_run >= SC), 64'd1);
          ro_len = 0;
          c_race++;
        end
        if (ro_enable == '1) ro_len++;
        if (ro_enable != '1 && prev_ro)
          check("race_len", 64'(ro_len), 64'((mode == M_NONE) ? TC : DW + SS));
        if (resp_valid) begin
          check("resp_word", response, model_resp(mode));
          check("resp_timeout", 64'(timeout_err), 64'(mode == M_NONE));
          check("busy_with_valid", 64'(busy), 64'd1);
        end
        prev_ro = (ro_enable == '1);
      end
    end
  end

  task automatic run_req(input int m, input logic [CW-1:0] s, input bit hold,
                         output logic [NB-1:0] got, output logic got_tmo);
    int n;
    mode = m;
    seed_v = s;
    resp_ready = !hold;
    seed = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    seed = ~s;
    check("busy_on_start", 64'(busy), 64'd1);
    tick(30);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!resp_valid && n < 20000) begin
      tick();
      n++;
    end
    check("resp_valid_seen", 64'(resp_valid), 64'd1);
    got = response;
    got_tmo = timeout_err;
    if (hold) begin
      for (int i = 0; i < 20; i++) begin
        if (i % 5 == 2) start = 1'b1;
        tick();
        start = 1'b0;
        check("hold_valid", 64'(resp_valid), 64'd1);
        check("hold_word", response, model_resp(m));
        check("hold_busy", 64'(busy), 64'd1);
      end
      resp_ready = 1'b1;
    end
    tick();
    check("valid_drop", 64'(resp_valid), 64'd0);
    check("busy_drop", 64'(busy), 64'd0);
    tick(3);
    check("stay_idle", 64'(busy), 64'd0);
    $display("req mode=%0d seed=%h hold=%0d response=%h timeout_err=%0d", m, s, hold, got, got_tmo);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NB-1:0] got;
    logic          got_tmo;
    int            n;
    reset = 1'b1;
    start = 1'b0;
    seed = '0;
    resp_ready = 1'b1;
    tick(3);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(resp_valid), 64'd0);
    check("rst_response", response, 64'd0);
    check("rst_timeout", 64'(timeout_err), 64'd0);
    check("rst_ro_enable", ro_enable, 64'd0);
    check("rst_challenge", 64'(challenge), 64'd0);
    check("rst_cnt_reset", 64'(cnt_reset), 64'd1);
    reset = 1'b0;
    tick(2);
    check("idle_busy", 64'(busy), 64'd0);

    // T1: reset while racing
    mode = M_FIN1;
    seed_v = 10'h100;
    seed = 10'h100;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (ro_enable !== '1 && n < 200) begin
      tick();
      n++;
    end
    check("t1_in_run", 64'(ro_enable == '1), 64'd1);
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("t1_async_ro_enable", ro_enable, 64'd0);
    check("t1_async_cnt_reset", 64'(cnt_reset), 64'd1);
    tick(2);
    reset = 1'b0;
    tick();
    check("t1_busy", 64'(busy), 64'd0);
    check("t1_valid", 64'(resp_valid), 64'd0);
    check("t1_response", response, 64'd0);
    check("t1_challenge", 64'(challenge), 64'd0);
    $display("req T1 reset mid-race busy=%0d resp_valid=%0d", busy, resp_valid);

`ifdef VON_NEUMANN_DEBIAS_EN
    // Equal-time races with alternating led: every pair is 10
    run_req(M_SAME, 10'h012, 1'b0, got, got_tmo);
    check("vn_same_word", got, 64'hFFFF_FFFF_FFFF_FFFF);
    // T6: race pattern 1,1,0 repeating
    run_req(M_PAT, 10'h200, 1'b0, got, got_tmo);
    check("t6_word", got, 64'hAAAA_AAAA_AAAA_AAAA);
    check("t6_timeout", 64'(got_tmo), 64'd0);
    check("t6_chal2", 64'(chal_log[2]), 64'h201);
    // T5
    run_req(M_SAME, 10'h0F0, 1'b1, got, got_tmo);
    check("t5_word", got, 64'hFFFF_FFFF_FFFF_FFFF);
`else
    // T2
    run_req(M_FIN1, 10'h3FF, 1'b0, got, got_tmo);
    check("t2_word", got, 64'hFFFF_FFFF_FFFF_FFFF);
    check("t2_chal0", 64'(chal_log[0]), 64'h3FF);
    check("t2_chal1", 64'(chal_log[1]), 64'h000);
    check("t2_chal63", 64'(chal_log[63]), 64'h03E);
    // T3
    run_req(M_SAME, 10'h012, 1'b0, got, got_tmo);
    check("t3_word", got, 64'h5555_5555_5555_5555);
    // T4
    run_req(M_NONE, 10'h2A0, 1'b0, got, got_tmo);
    check("t4_word", got, 64'd0);
    check("t4_timeout", 64'(got_tmo), 64'd1);
    // Mixed winners 1,1,0 repeating
    run_req(M_PAT, 10'h040, 1'b0, got, got_tmo);
    check("pat_word", got, 64'hB6DB_6DB6_DB6D_B6DB);
    check("pat_timeout", 64'(got_tmo), 64'd0);
    // T5
    run_req(M_SAME, 10'h0F0, 1'b1, got, got_tmo);
    check("t5_word", got, 64'h5555_5555_5555_5555);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
